// File: rtl/udp_segment_scheduler.sv
// -----------------------------------------------------------------------------
// udp_segment_scheduler
//
// Purpose
//   Drives the byte_data UDP frame generator for one video frame. A frame_go
//   pulse launches SEGS_PER_FRAME segments, each sent N_CLONES times. For every
//   packet the block supplies segment_num, index_clone, aux (frame sequence
//   number) and startaddr, then waits for the generator to take and finish it.
//   An idle gap of GAP_CYCLES clocks separates generator-done from the next
//   start.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         scheduler enable; low stops after the current packet
//   frame_go       1-cycle pulse requesting a new frame
//   tx_busy        generator busy
//   tx_counter     generator byte counter (0 = idle)
//   start          launch request to the generator
//   segment_num    segment index of the current packet
//   index_clone    clone index of the current packet
//   aux            frame sequence number, mod 256
//   startaddr      segment_num * PAYLOAD_BYTES (kept by an accumulator)
//   active         a frame is in progress
//   frame_done     1-cycle pulse when the last packet of a frame completes
//   overrun        sticky: frame_go arrived while a frame was in progress
//   timeout_err    sticky watchdog flag (0 unless the watchdog is built in)
//   dbg_state      current FSM state, for observation only
//
// Configuration
//   SCHED_TIMEOUT_EN  when defined, adds the TIMEOUT_CYCLES parameter and a
//                     per-packet watchdog over WAIT_ACK + WAIT_DONE. When not
//                     defined there is no watchdog and timeout_err is tied 0.
//
// Handshake with the generator
//   start is raised in LAUNCH and held until tx_counter reads non-zero; that
//   non-zero value is the acknowledge and start falls on the same edge. The
//   packet is complete once tx_counter == 0 and tx_busy == 0.
// -----------------------------------------------------------------------------
module udp_segment_scheduler #(
   parameter int unsigned SEGS_PER_FRAME = 40,
   parameter int unsigned PAYLOAD_BYTES  = 1440,
   parameter int unsigned N_CLONES       = 3,
   parameter int unsigned GAP_CYCLES     = 12
`ifdef SCHED_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        frame_go,
   input  logic        tx_busy,
   input  logic [11:0] tx_counter,
   output logic        start,
   output logic [15:0] segment_num,
   output logic [7:0]  index_clone,
   output logic [7:0]  aux,
   output logic [23:0] startaddr,
   output logic        active,
   output logic        frame_done,
   output logic        overrun,
   output logic        timeout_err,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_ACK  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_GAP       = 3'd4
   } state_e;

   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_e        state_q;
   logic          start_q, active_q, frame_done_q, overrun_q;
   logic [15:0]   seg_q;
   logic [7:0]    clone_q, aux_q;
   logic [23:0]   addr_q;
   logic [GW-1:0] gap_q;

   // Next-packet indices, used only on GAP exit.
   logic          last_clone_d, last_seg_d, acked_d, gen_idle_d;
   logic [15:0]   seg_d;
   logic [7:0]    clone_d;
   logic [23:0]   addr_d;

   always_comb begin
      last_clone_d = (clone_q == 8'(N_CLONES - 1));
      last_seg_d   = (seg_q == 16'(SEGS_PER_FRAME - 1));
      acked_d      = (tx_counter != 12'd0);
      gen_idle_d   = (tx_counter == 12'd0) && !tx_busy;
      seg_d        = seg_q;
      clone_d      = clone_q + 8'd1;
      addr_d       = addr_q;
      if (last_clone_d) begin
         clone_d = 8'd0;
         seg_d   = seg_q + 16'd1;
         addr_d  = addr_q + 24'(PAYLOAD_BYTES);
      end
   end

`ifdef SCHED_TIMEOUT_EN
   localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WD_W-1:0] wd_q;
   logic            timeout_err_q;
   logic            wd_trip;
   // Trips after TIMEOUT_CYCLES clocks spent in WAIT_ACK + WAIT_DONE.
   assign wd_trip     = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         start_q      <= 1'b0;
         active_q     <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         seg_q        <= 16'd0;
         clone_q      <= 8'd0;
         aux_q        <= 8'd0;
         addr_q       <= 24'd0;
         gap_q        <= '0;
`ifdef SCHED_TIMEOUT_EN
         wd_q          <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         frame_done_q <= 1'b0;
         // The frame_done cycle still counts as busy: a new frame has to be
         // requested once the block is visibly idle.
         if (frame_go && (active_q || frame_done_q)) overrun_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (frame_go && enable && !frame_done_q) begin
                  state_q  <= S_LAUNCH;
                  start_q  <= 1'b1;
                  active_q <= 1'b1;
                  seg_q    <= 16'd0;
                  clone_q  <= 8'd0;
                  addr_q   <= 24'd0;
               end
            end

            S_LAUNCH, S_WAIT_ACK: begin
`ifdef SCHED_TIMEOUT_EN
               if (state_q == S_LAUNCH) wd_q <= '0;
               else                     wd_q <= wd_q + 1'b1;
               if ((state_q == S_WAIT_ACK) && wd_trip) begin
                  start_q       <= 1'b0;
                  active_q      <= 1'b0;
                  timeout_err_q <= 1'b1;
                  state_q       <= S_IDLE;
               end else
`endif
               if (acked_d) begin
                  start_q <= 1'b0;
                  state_q <= S_WAIT_DONE;
               end else if (!enable) begin
                  // Abandon a packet the generator has not taken yet.
                  start_q  <= 1'b0;
                  active_q <= 1'b0;
                  state_q  <= S_IDLE;
               end else begin
                  state_q <= S_WAIT_ACK;
               end
            end

            S_WAIT_DONE: begin
`ifdef SCHED_TIMEOUT_EN
               wd_q <= wd_q + 1'b1;
               if (wd_trip) begin
                  active_q      <= 1'b0;
                  timeout_err_q <= 1'b1;
                  state_q       <= S_IDLE;
               end else
`endif
               if (gen_idle_d) begin
                  gap_q   <= GW'(GAP_CYCLES - 1);
                  state_q <= S_GAP;
               end
            end

            S_GAP: begin
               if (gap_q != '0) begin
                  gap_q <= gap_q - 1'b1;
               end else if (last_clone_d && last_seg_d) begin
                  frame_done_q <= 1'b1;
                  aux_q        <= aux_q + 8'd1;
                  active_q     <= 1'b0;
                  state_q      <= S_IDLE;
               end else begin
                  seg_q   <= seg_d;
                  clone_q <= clone_d;
                  addr_q  <= addr_d;
                  if (enable) begin
                     start_q <= 1'b1;
                     state_q <= S_LAUNCH;
                  end else begin
                     active_q <= 1'b0;
                     state_q  <= S_IDLE;
                  end
               end
            end

            default: begin
               start_q  <= 1'b0;
               active_q <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign start       = start_q;
   assign segment_num = seg_q;
   assign index_clone = clone_q;
   assign aux         = aux_q;
   assign startaddr   = addr_q;
   assign active      = active_q;
   assign frame_done  = frame_done_q;
   assign overrun     = overrun_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_udp_segment_scheduler.sv
// -----------------------------------------------------------------------------
// tb_udp_segment_scheduler
//   Directed bench for udp_segment_scheduler with 3 segments x 2 clones,
//   1440-byte payload step and a 4-clock gap. A generator model acknowledges a
//   start 2 clocks after it rises and runs a 20-clock packet. Packets seen at
//   each start rising edge are checked against an expected queue.
// -----------------------------------------------------------------------------
module tb_udp_segment_scheduler;

   localparam int SEGS = 3;
   localparam int CL   = 2;
   localparam int PB   = 1440;
   localparam int GAP  = 4;
   localparam int TO   = 64;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        frame_go = 1'b0;
   logic        tx_busy = 1'b0;
   logic [11:0] tx_counter = 12'd0;
   logic        start, active, frame_done, overrun, timeout_err;
   logic [15:0] segment_num;
   logic [7:0]  index_clone, aux;
   logic [23:0] startaddr;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   udp_segment_scheduler #(
`ifdef SCHED_TIMEOUT_EN
      .TIMEOUT_CYCLES(TO),
`endif
      .SEGS_PER_FRAME(SEGS),
      .PAYLOAD_BYTES (PB),
      .N_CLONES      (CL),
      .GAP_CYCLES    (GAP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .frame_go   (frame_go),
      .tx_busy    (tx_busy),
      .tx_counter (tx_counter),
      .start      (start),
      .segment_num(segment_num),
      .index_clone(index_clone),
      .aux        (aux),
      .startaddr  (startaddr),
      .active     (active),
      .frame_done (frame_done),
      .overrun    (overrun),
      .timeout_err(timeout_err),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int          tests_run = 0;
   int          tests_failed = 0;
   logic [55:0] exp_q[$];
   int          cyc = 0;
   int          cnt0_cyc = 0;
   bit          gap_armed = 1'b0;
   bit          start_prev = 1'b0;
   bit          ack_en = 1'b1;
   int          busy_viol = 0;
   int          unexp = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- generator model + packet monitor ----------------
   initial begin : gen_model
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            ph         = 0;
            tx_counter = 12'd0;
            tx_busy    = 1'b0;
            start_prev = 1'b0;
            gap_armed  = 1'b0;
         end else begin
            if (start && !start_prev) begin
               if (gap_armed) begin
                  chk("gap_to_start", 64'(cyc - cnt0_cyc), 64'(GAP + 1));
                  gap_armed = 1'b0;
               end
               if (exp_q.size() == 0) unexp++;
               else chk("packet", {segment_num, index_clone, aux, startaddr}, exp_q.pop_front());
            end
            start_prev = start;
            if (start && tx_counter >= 12'd2) busy_viol++;
            case (ph)
               0: if (start && ack_en) ph = 1;
               1: begin
                  tx_counter = 12'd1;
                  tx_busy    = 1'b1;
                  ph         = 2;
               end
               default: begin
                  if (tx_counter == 12'd20) begin
                     tx_counter = 12'd0;
                     tx_busy    = 1'b0;
                     ph         = 0;
                     cnt0_cyc   = cyc;
                     gap_armed  = 1'b1;
                  end else begin
                     tx_counter = tx_counter + 12'd1;
                  end
               end
            endcase
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_go();
      gap_armed = 1'b0;
      frame_go  = 1'b1;
      step();
      frame_go  = 1'b0;
   endtask

   task automatic push_frame(input logic [7:0] a);
      for (int s = 0; s < SEGS; s++)
         for (int c = 0; c < CL; c++)
            exp_q.push_back({16'(s), 8'(c), a, 24'(s * PB)});
   endtask

   task automatic wait_frame_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         step();
         if (frame_done) seen = 1'b1;
      end
      chk(tag, 64'(seen), 64'd1);
   endtask

   task automatic wait_busy_after(input int remaining, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         step();
         if (exp_q.size() == remaining && tx_busy) seen = 1'b1;
      end
      chk(tag, 64'(seen), 64'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      bit fd_seen;
      logic [7:0] exp_aux;

      // Reset state
      repeat (3) step();
      chk("rst_start", 64'(start), 64'd0);
      chk("rst_active", 64'(active), 64'd0);
      chk("rst_aux", 64'(aux), 64'd0);
      chk("rst_seg", 64'(segment_num), 64'd0);
      chk("rst_addr", 64'(startaddr), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      chk("rst_timeout", 64'(timeout_err), 64'd0);
      rst_n = 1'b1;
      step();

      // frame_go with enable low is ignored without a flag
      pulse_go();
      step();
      chk("dis_start", 64'(start), 64'd0);
      chk("dis_active", 64'(active), 64'd0);
      chk("dis_overrun", 64'(overrun), 64'd0);
      enable = 1'b1;
      step();

      // Full frame: six packets in order, one frame_done, aux advances
      push_frame(8'd0);
      pulse_go();
      chk("latency_start", 64'(start), 64'd1);
      chk("latency_active", 64'(active), 64'd1);
      wait_frame_done("f1_done");
      chk("f1_aux_after", 64'(aux), 64'd1);
      chk("f1_active_low", 64'(active), 64'd0);
      step();
      chk("f1_done_pulse", 64'(frame_done), 64'd0);
      chk("f1_all_pkts", 64'(exp_q.size()), 64'd0);
      chk("f1_overrun", 64'(overrun), 64'd0);

      // frame_go during packet 3 sets overrun, frame unaffected
      push_frame(8'd1);
      pulse_go();
      wait_busy_after(3, "p3_reached");
      frame_go = 1'b1;
      step();
      frame_go = 1'b0;
      chk("overrun_set", 64'(overrun), 64'd1);
      wait_frame_done("f2_done");
      chk("f2_aux_after", 64'(aux), 64'd2);
      step();
      chk("f2_overrun_sticky", 64'(overrun), 64'd1);
      chk("f2_all_pkts", 64'(exp_q.size()), 64'd0);

      // 256 back-to-back frames: aux passes 255 -> 0 and returns to 2
      exp_aux = 8'd2;
      for (int f = 0; f < 256; f++) begin
         push_frame(exp_aux);
         pulse_go();
         wait_frame_done("bb_done");
         exp_aux = exp_aux + 8'd1;
         chk("bb_aux", 64'(aux), 64'(exp_aux));
         step();
      end
      chk("bb_all_pkts", 64'(exp_q.size()), 64'd0);

      // enable dropped while packet 2 is in flight: it completes, nothing more
      exp_q.push_back({16'd0, 8'd0, 8'd2, 24'd0});
      exp_q.push_back({16'd0, 8'd1, 8'd2, 24'd0});
      pulse_go();
      wait_busy_after(0, "stop_p2_reached");
      enable  = 1'b0;
      fd_seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (frame_done) fd_seen = 1'b1;
      end
      chk("stop_start", 64'(start), 64'd0);
      chk("stop_active", 64'(active), 64'd0);
      chk("stop_no_done", 64'(fd_seen), 64'd0);
      chk("stop_aux", 64'(aux), 64'd2);
      chk("stop_extra_starts", 64'(unexp), 64'd0);
      enable = 1'b1;
      step();

      // Asynchronous reset in the middle of WAIT_DONE
      exp_q.push_back({16'd0, 8'd0, 8'd2, 24'd0});
      pulse_go();
      wait_busy_after(0, "rst_pkt_busy");
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_start", 64'(start), 64'd0);
      chk("arst_active", 64'(active), 64'd0);
      chk("arst_aux", 64'(aux), 64'd0);
      chk("arst_overrun", 64'(overrun), 64'd0);
      chk("arst_idx", 64'({segment_num, index_clone, startaddr}), 64'd0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      push_frame(8'd0);
      pulse_go();
      wait_frame_done("after_rst_done");
      chk("after_rst_aux", 64'(aux), 64'd1);
      step();

      // Generator never acknowledges
      ack_en = 1'b0;
      exp_q.push_back({16'd0, 8'd0, 8'd1, 24'd0});
      pulse_go();
      repeat (60) step();
      chk("noack_start_held", 64'(start), 64'd1);
      repeat (10) step();
`ifdef SCHED_TIMEOUT_EN
      chk("to_start_dropped", 64'(start), 64'd0);
      chk("to_flag", 64'(timeout_err), 64'd1);
      chk("to_active", 64'(active), 64'd0);
      chk("to_aux", 64'(aux), 64'd1);
`else
      chk("noto_start", 64'(start), 64'd1);
      chk("noto_flag", 64'(timeout_err), 64'd0);
      chk("noto_active", 64'(active), 64'd1);
`endif
      chk("no_start_while_busy", 64'(busy_viol), 64'd0);
      chk("no_extra_starts", 64'(unexp), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
